// File: rtl/lives_hud.sv
// lives_hud: N-heart lives indicator for the VGA status strip.
// Hearts are fetched from the shared 16x16 sprite BRAM. Losing a life makes
// the affected hearts blink before they vanish. Gaining a life makes the new
// hearts flash white. All life changes are applied on frame_tick only.
module lives_hud #(
  parameter int MAX_LIVES    = 5,
  parameter int LIVES_W      = 3,
  parameter int HEART_W      = 16,
  parameter int HEART_H      = 16,
  parameter int X_START      = 160,
  parameter int Y_POS        = 456,
  parameter int SPACING      = 8,
  parameter int BLINK_FRAMES = 24,
  parameter int BLINK_HALF   = 4,
  parameter int FLASH_FRAMES = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [LIVES_W-1:0] lives_in,
  input  logic [9:0]         h_count,
  input  logic [8:0]         v_count,
  output logic [3:0]         sprite_x,
  output logic [3:0]         sprite_y,
  input  logic [5:0]         pixel_data,
  output logic [2:0]         vga_r,
  output logic [2:0]         vga_g,
  output logic [2:0]         vga_b,
  output logic               pixel_active,
  output logic               anim_busy
);

  localparam int PITCH = HEART_W + SPACING;
  localparam int LV_W  = 4;
  localparam int BC_W  = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam int HC_W  = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam int FC_W  = (FLASH_FRAMES > 2) ? $clog2(FLASH_FRAMES) : 1;

  // Geometry sanity: the whole strip must sit inside the visible 640x480 area.
  if (X_START + MAX_LIVES * (HEART_W + SPACING) - SPACING > 640) begin : g_bad_x
    $error("lives_hud: heart strip extends past column 640");
  end
  if (Y_POS + HEART_H > 480) begin : g_bad_y
    $error("lives_hud: heart strip extends past row 480");
  end
  if (MAX_LIVES < 1 || MAX_LIVES > 8) begin : g_bad_n
    $error("lives_hud: MAX_LIVES must be within 1..8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    FLASH = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [LV_W-1:0]  shown_lives, shown_n;
  logic [LV_W-1:0]  blink_lo, blink_lo_n;
  logic [LV_W-1:0]  flash_lo, flash_lo_n;
  logic [BC_W-1:0]  blink_cnt, blink_cnt_n;
  logic [HC_W-1:0]  half_cnt, half_cnt_n;
  logic             phase, phase_n;
  logic [FC_W-1:0]  flash_cnt, flash_cnt_n;
  logic [LV_W-1:0]  target;

  logic             hit;
  logic [2:0]       hit_k;
  logic [3:0]       hit_x;
  logic [3:0]       hit_y;
  logic             row_hit;
  logic [2:0]       k_s1, k_s2;
  logic             in_strip_s1, in_strip_s2;

  logic [LV_W-1:0]  slot;
  logic             visible;
  logic             white;
  logic [2:0]       r_n, g_n, b_n;
  logic             active_n;

  // Clamp the requested life count to the number of slots.
  always_comb begin
    if (32'(lives_in) > 32'(MAX_LIVES)) target = LV_W'(MAX_LIVES);
    else                                target = LV_W'(lives_in);
  end

  // Slot decode against constant per-slot start columns, so no divider is needed.
  always_comb begin
    hit     = 1'b0;
    hit_k   = '0;
    hit_x   = '0;
    row_hit = (v_count >= 9'(Y_POS)) && (v_count < 9'(Y_POS + HEART_H));
    hit_y   = 4'(v_count - 9'(Y_POS));
    for (int k = 0; k < MAX_LIVES; k++) begin
      if ((h_count >= 10'(X_START + k * PITCH)) &&
          (h_count <  10'(X_START + k * PITCH + HEART_W))) begin
        hit   = row_hit;
        hit_k = 3'(k);
        hit_x = 4'(h_count - 10'(X_START + k * PITCH));
      end
    end
  end

  // Address stage plus one delay stage that keeps slot info aligned with BRAM data.
  always_ff @(posedge clk) begin
    if (reset) begin
      sprite_x    <= '0;
      sprite_y    <= '0;
      k_s1        <= '0;
      in_strip_s1 <= 1'b0;
      k_s2        <= '0;
      in_strip_s2 <= 1'b0;
    end else begin
      sprite_x    <= hit ? hit_x : 4'd0;
      sprite_y    <= hit ? hit_y : 4'd0;
      k_s1        <= hit ? hit_k : 3'd0;
      in_strip_s1 <= hit;
      k_s2        <= k_s1;
      in_strip_s2 <= in_strip_s1;
    end
  end

  // Animation state register; anim_busy follows the registered state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shown_lives <= '0;
      blink_lo    <= '0;
      flash_lo    <= '0;
      blink_cnt   <= '0;
      half_cnt    <= '0;
      phase       <= 1'b0;
      flash_cnt   <= '0;
      anim_busy   <= 1'b0;
    end else begin
      state       <= state_n;
      shown_lives <= shown_n;
      blink_lo    <= blink_lo_n;
      flash_lo    <= flash_lo_n;
      blink_cnt   <= blink_cnt_n;
      half_cnt    <= half_cnt_n;
      phase       <= phase_n;
      flash_cnt   <= flash_cnt_n;
      anim_busy   <= (state_n != IDLE);
    end
  end

  // Next-state logic, only advancing on frame_tick so a frame never tears.
  always_comb begin
    state_n     = state;
    shown_n     = shown_lives;
    blink_lo_n  = blink_lo;
    flash_lo_n  = flash_lo;
    blink_cnt_n = blink_cnt;
    half_cnt_n  = half_cnt;
    phase_n     = phase;
    flash_cnt_n = flash_cnt;
    if (frame_tick) begin
      unique case (state)
        IDLE: begin
          if (target < shown_lives) begin
            state_n     = BLINK;
            blink_lo_n  = target;
            blink_cnt_n = '0;
            half_cnt_n  = '0;
            phase_n     = 1'b1;
          end else if (target > shown_lives) begin
            state_n     = FLASH;
            flash_lo_n  = shown_lives;
            shown_n     = target;
            flash_cnt_n = '0;
          end
        end
        BLINK: begin
          if (target >= shown_lives) begin
            if (target > shown_lives) begin
              state_n     = FLASH;
              flash_lo_n  = shown_lives;
              shown_n     = target;
              flash_cnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else if (target < blink_lo) begin
            blink_lo_n  = target;
            blink_cnt_n = '0;
            half_cnt_n  = '0;
            phase_n     = 1'b1;
          end else begin
            blink_lo_n = target;
            if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
              shown_n = target;
              state_n = IDLE;
            end else begin
              blink_cnt_n = blink_cnt + 1'b1;
              if (half_cnt == HC_W'(BLINK_HALF - 1)) begin
                half_cnt_n = '0;
                phase_n    = ~phase;
              end else begin
                half_cnt_n = half_cnt + 1'b1;
              end
            end
          end
        end
        FLASH: begin
          if (target < shown_lives) begin
            state_n     = BLINK;
            blink_lo_n  = target;
            blink_cnt_n = '0;
            half_cnt_n  = '0;
            phase_n     = 1'b1;
          end else if (target > shown_lives) begin
            shown_n     = target;
            flash_cnt_n = '0;
          end else if (flash_cnt == FC_W'(FLASH_FRAMES - 1)) begin
            state_n = IDLE;
          end else begin
            flash_cnt_n = flash_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Pixel colour: visibility, transparency, white flash and 2-to-3 bit expansion.
  always_comb begin
    slot     = {1'b0, k_s2};
    visible  = ((slot < shown_lives) && (state != BLINK)) ||
               (slot < blink_lo) ||
               ((state == BLINK) && (slot >= blink_lo) && (slot < shown_lives) && phase);
    white    = (state == FLASH) && (slot >= flash_lo) && (slot < shown_lives);
    r_n      = 3'd0;
    g_n      = 3'd0;
    b_n      = 3'd0;
    active_n = 1'b0;
    if (in_strip_s2 && visible && (pixel_data != 6'd0)) begin
      active_n = 1'b1;
      if (white) begin
        r_n = 3'b111;
        g_n = 3'b111;
        b_n = 3'b111;
      end else begin
        r_n = {pixel_data[5:4], pixel_data[5]};
        g_n = {pixel_data[3:2], pixel_data[3]};
        b_n = {pixel_data[1:0], pixel_data[1]};
      end
    end
  end

  // Registered overlay output for the top-level pixel mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_r        <= '0;
      vga_g        <= '0;
      vga_b        <= '0;
      pixel_active <= 1'b0;
    end else begin
      vga_r        <= r_n;
      vga_g        <= g_n;
      vga_b        <= b_n;
      pixel_active <= active_n;
    end
  end

endmodule

// File: tb/tb_lives_hud.sv
// tb_lives_hud: directed bench for lives_hud with a registered sprite BRAM model.
module tb_lives_hud;

  localparam int MAX_LIVES    = 5;
  localparam int HEART_W      = 16;
  localparam int HEART_H      = 16;
  localparam int X_START      = 160;
  localparam int Y_POS        = 456;
  localparam int SPACING      = 8;
  localparam int PITCH        = HEART_W + SPACING;
  localparam int BLINK_FRAMES = 24;
  localparam int BLINK_HALF   = 4;
  localparam int FLASH_FRAMES = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [2:0] lives_in;
  logic [9:0] h_count;
  logic [8:0] v_count;
  logic [3:0] sprite_x, sprite_y;
  logic [5:0] pixel_data;
  logic [2:0] vga_r, vga_g, vga_b;
  logic       pixel_active, anim_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [9:0] h;
    logic [8:0] v;
    logic [3:0] sx;
    logic [3:0] sy;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    logic       act;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  lives_hud #(
    .MAX_LIVES(MAX_LIVES), .LIVES_W(3), .HEART_W(HEART_W), .HEART_H(HEART_H),
    .X_START(X_START), .Y_POS(Y_POS), .SPACING(SPACING),
    .BLINK_FRAMES(BLINK_FRAMES), .BLINK_HALF(BLINK_HALF), .FLASH_FRAMES(FLASH_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .lives_in(lives_in),
    .h_count(h_count), .v_count(v_count), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .pixel_data(pixel_data), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pixel_active(pixel_active), .anim_busy(anim_busy)
  );

  // Sprite content: column 1 is transparent, (0,0) is pure red.
  function automatic logic [5:0] rom_pix(input logic [3:0] x, input logic [3:0] y);
    if (x == 4'd1) return 6'b000000;
    if (x == 4'd0 && y == 4'd0) return 6'b110000;
    return {x[3:2], y[1:0], x[1:0]};
  endfunction

  // BRAM model with one clock of read latency.
  always @(posedge clk) pixel_data <= rom_pix(sprite_x, sprite_y);

  // Expected {in_slot, sx, sy} from screen position, using division.
  function automatic logic [8:0] model_addr(input int h, input int v);
    int off, k, col;
    model_addr = '0;
    if (v >= Y_POS && v < Y_POS + HEART_H && h >= X_START) begin
      off = h - X_START;
      k   = off / PITCH;
      col = off % PITCH;
      if (k < MAX_LIVES && col < HEART_W) model_addr = {1'b1, 4'(col), 4'(v - Y_POS)};
    end
  endfunction

  // Expected {active, r, g, b} for a pixel given visibility and flash status.
  function automatic logic [9:0] model_rgb(input logic [5:0] pix, input logic vis,
                                           input logic white, input logic in_slot);
    if (!in_slot || !vis || pix == 6'd0) return 10'd0;
    if (white) return {1'b1, 9'h1FF};
    return {1'b1, pix[5:4], pix[5], pix[3:2], pix[3], pix[1:0], pix[1]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] h, input logic [8:0] v);
    @(negedge clk);
    h_count = h;
    v_count = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic probe_slot(input string name, input int h, input int v,
                            input logic vis, input logic white);
    logic [8:0] a;
    logic [9:0] e;
    applyStimulus(10'(h), 9'(v));
    a = model_addr(h, v);
    e = model_rgb(rom_pix(a[7:4], a[3:0]), vis, white, a[8]);
    checkOutput({name, "_sx"}, 32'(sprite_x), 32'(a[7:4]));
    checkOutput({name, "_sy"}, 32'(sprite_y), 32'(a[3:0]));
    checkOutput({name, "_r"}, 32'(vga_r), 32'(e[8:6]));
    checkOutput({name, "_g"}, 32'(vga_g), 32'(e[5:3]));
    checkOutput({name, "_b"}, 32'(vga_b), 32'(e[2:0]));
    checkOutput({name, "_act"}, 32'(pixel_active), 32'(e[9]));
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic on;

    // Steady-state table, valid with three hearts shown and no animation.
    vecs[0]  = '{10'd160, 9'd456, 4'd0,  4'd0,  3'b111, 3'b000, 3'b000, 1'b1};
    vecs[1]  = '{10'd185, 9'd456, 4'd1,  4'd0,  3'b000, 3'b000, 3'b000, 1'b0};
    vecs[2]  = '{10'd176, 9'd456, 4'd0,  4'd0,  3'b000, 3'b000, 3'b000, 1'b0};
    vecs[3]  = '{10'd210, 9'd461, 4'd2,  4'd5,  3'b000, 3'b010, 3'b101, 1'b1};
    vecs[4]  = '{10'd239, 9'd471, 4'd7,  4'd15, 3'b000, 3'b000, 3'b000, 1'b0};
    vecs[5]  = '{10'd255, 9'd456, 4'd0,  4'd0,  3'b000, 3'b000, 3'b000, 1'b0};
    vecs[6]  = '{10'd271, 9'd470, 4'd15, 4'd14, 3'b000, 3'b000, 3'b000, 1'b0};
    vecs[7]  = '{10'd160, 9'd455, 4'd0,  4'd0,  3'b000, 3'b000, 3'b000, 1'b0};
    vecs[8]  = '{10'd175, 9'd471, 4'd15, 4'd15, 3'b111, 3'b111, 3'b111, 1'b1};
    vecs[9]  = '{10'd196, 9'd466, 4'd12, 4'd10, 3'b111, 3'b101, 3'b000, 1'b1};
    vecs[10] = '{10'd159, 9'd460, 4'd0,  4'd0,  3'b000, 3'b000, 3'b000, 1'b0};
    vecs[11] = '{10'd224, 9'd472, 4'd0,  4'd0,  3'b000, 3'b000, 3'b000, 1'b0};
    vecs[12] = '{10'd217, 9'd459, 4'd9,  4'd3,  3'b101, 3'b111, 3'b010, 1'b1};

    reset      = 1'b1;
    frame_tick = 1'b0;
    lives_in   = 3'd3;
    h_count    = 10'd175;
    v_count    = 9'd471;
    repeat (4) @(negedge clk);
    checkOutput("rst_sx", 32'(sprite_x), 0);
    checkOutput("rst_sy", 32'(sprite_y), 0);
    checkOutput("rst_r", 32'(vga_r), 0);
    checkOutput("rst_act", 32'(pixel_active), 0);
    checkOutput("rst_busy", 32'(anim_busy), 0);
    reset = 1'b0;

    // No hearts before the first frame_tick.
    probe_slot("pre_s0", 160, 456, 1'b0, 1'b0);
    checkOutput("pre_busy", 32'(anim_busy), 0);

    // Gain 0->3: six white frames on slots 0-2.
    frame_pulse();
    for (int f = 0; f < FLASH_FRAMES; f++) begin
      checkOutput($sformatf("flash_busy_f%0d", f), 32'(anim_busy), 1);
      probe_slot("flash_s0", 160, 456, 1'b1, 1'b1);
      probe_slot("flash_s2", 217, 459, 1'b1, 1'b1);
      probe_slot("flash_s3", 234, 456, 1'b0, 1'b0);
      frame_pulse();
    end
    checkOutput("flash_end_busy", 32'(anim_busy), 0);
    probe_slot("flash_end_s0", 160, 456, 1'b1, 1'b0);

    // Steady-state table.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].h, vecs[i].v);
      checkOutput($sformatf("vec%0d_sx", i), 32'(sprite_x), 32'(vecs[i].sx));
      checkOutput($sformatf("vec%0d_sy", i), 32'(sprite_y), 32'(vecs[i].sy));
      checkOutput($sformatf("vec%0d_r", i), 32'(vga_r), 32'(vecs[i].r));
      checkOutput($sformatf("vec%0d_g", i), 32'(vga_g), 32'(vecs[i].g));
      checkOutput($sformatf("vec%0d_b", i), 32'(vga_b), 32'(vecs[i].b));
      checkOutput($sformatf("vec%0d_act", i), 32'(pixel_active), 32'(vecs[i].act));
    end

    // Latency: address after one clock, colour after three.
    applyStimulus(10'd175, 9'd471);
    @(negedge clk);
    h_count = 10'd160;
    v_count = 9'd456;
    @(negedge clk);
    checkOutput("lat_sx_c1", 32'(sprite_x), 0);
    checkOutput("lat_sy_c1", 32'(sprite_y), 0);
    checkOutput("lat_g_c1", 32'(vga_g), 32'h7);
    @(negedge clk);
    checkOutput("lat_g_c2", 32'(vga_g), 32'h7);
    @(negedge clk);
    checkOutput("lat_r_c3", 32'(vga_r), 32'h7);
    checkOutput("lat_g_c3", 32'(vga_g), 0);
    checkOutput("lat_act_c3", 32'(pixel_active), 1);

    // Loss 3->2: slot 2 blinks 4 on / 4 off for 24 frames, then disappears.
    lives_in = 3'd2;
    frame_pulse();
    for (int f = 0; f < BLINK_FRAMES; f++) begin
      on = ((f / BLINK_HALF) % 2) == 0;
      checkOutput($sformatf("blink_busy_f%0d", f), 32'(anim_busy), 1);
      probe_slot("blink_s1", 196, 466, 1'b1, 1'b0);
      probe_slot($sformatf("blink_s2_f%0d", f), 217, 459, on, 1'b0);
      frame_pulse();
    end
    checkOutput("loss_busy", 32'(anim_busy), 0);
    probe_slot("loss_s2_off", 217, 459, 1'b0, 1'b0);
    frame_pulse();
    probe_slot("loss_s2_off2", 217, 459, 1'b0, 1'b0);
    probe_slot("loss_s1_on", 196, 466, 1'b1, 1'b0);

    // Regain 2->3: only slot 2 flashes.
    lives_in = 3'd3;
    frame_pulse();
    probe_slot("regain_s2", 217, 459, 1'b1, 1'b1);
    probe_slot("regain_s0", 160, 456, 1'b1, 1'b0);
    repeat (FLASH_FRAMES) frame_pulse();
    checkOutput("regain_busy", 32'(anim_busy), 0);

    // Double loss at blink frame 10: whole strip blinks for a fresh 24 frames.
    lives_in = 3'd2;
    frame_pulse();
    repeat (10) frame_pulse();
    probe_slot("dbl_f10_s2", 217, 459, 1'b1, 1'b0);
    lives_in = 3'd0;
    frame_pulse();
    for (int f = 0; f < BLINK_FRAMES; f++) begin
      on = ((f / BLINK_HALF) % 2) == 0;
      checkOutput($sformatf("dbl_busy_f%0d", f), 32'(anim_busy), 1);
      probe_slot($sformatf("dbl_s0_f%0d", f), 160, 456, on, 1'b0);
      probe_slot($sformatf("dbl_s2_f%0d", f), 217, 459, on, 1'b0);
      frame_pulse();
    end
    checkOutput("dbl_busy_end", 32'(anim_busy), 0);
    probe_slot("dbl_s0_off", 160, 456, 1'b0, 1'b0);
    probe_slot("dbl_s1_off", 196, 466, 1'b0, 1'b0);

    // Gain mid-blink with clamp: 3->2 blinking, then request 7 -> 5 hearts.
    lives_in = 3'd3;
    frame_pulse();
    repeat (FLASH_FRAMES) frame_pulse();
    lives_in = 3'd2;
    frame_pulse();
    repeat (2) frame_pulse();
    lives_in = 3'd7;
    frame_pulse();
    checkOutput("gain_busy", 32'(anim_busy), 1);
    probe_slot("gain_s3", 234, 456, 1'b1, 1'b1);
    probe_slot("gain_s4", 271, 470, 1'b1, 1'b1);
    probe_slot("gain_s0", 160, 456, 1'b1, 1'b0);
    probe_slot("gain_s2", 217, 459, 1'b1, 1'b0);
    repeat (FLASH_FRAMES) frame_pulse();
    checkOutput("gain_busy_end", 32'(anim_busy), 0);
    probe_slot("gain_s4_norm", 271, 470, 1'b1, 1'b0);

    // Reset mid-blink: nothing shown until the next tick flashes hearts in from 0.
    lives_in = 3'd2;
    frame_pulse();
    checkOutput("rmid_busy_pre", 32'(anim_busy), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rmid_busy", 32'(anim_busy), 0);
    probe_slot("rmid_s0", 160, 456, 1'b0, 1'b0);
    frame_pulse();
    checkOutput("rmid_busy_flash", 32'(anim_busy), 1);
    probe_slot("rmid_s0_fl", 160, 456, 1'b1, 1'b1);
    probe_slot("rmid_s1_fl", 196, 466, 1'b1, 1'b1);
    probe_slot("rmid_s2_fl", 217, 459, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lives_hud.md
Name: lives_hud

Overview:
- Parametrised N-heart lives indicator for the VGA HUD, drawn in the bottom status strip.
- Fetches pixels from the shared 16x16 heart sprite BRAM, which returns RRGGBB data one clock after address.
- Adds frame-synchronous animation: lost hearts blink before they disappear, and gained hearts flash white.
- Output is a registered RGB overlay with an opacity flag, consumed by the top-level pixel mux.

Parameters:
- MAX_LIVES, 5: number of heart slots (1..8).
- LIVES_W, 3: width of lives_in.
- HEART_W, 16: sprite width in pixels. Must equal the BRAM sprite width.
- HEART_H, 16: sprite height in pixels.
- X_START, 160: h_count of the first slot's left column.
- Y_POS, 456: v_count of the top row.
- SPACING, 8: gap in pixels between slots. Slot pitch = HEART_W+SPACING.
- BLINK_FRAMES, 24: total blink duration in frames.
- BLINK_HALF, 4: frames per visible/hidden half-period.
- FLASH_FRAMES, 6: white-flash duration in frames.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse at vblank start.
- lives_in  in  LIVES_W  requested life count from game logic.
- h_count  in  10  current column.
- v_count  in  9  current row.
- sprite_x  out  4  BRAM column address (registered).
- sprite_y  out  4  BRAM row address (registered).
- pixel_data  in  6  BRAM data {R[1:0],G[1:0],B[1:0]}, valid 1 clk after address.
- vga_r  out  3  red overlay.
- vga_g  out  3  green overlay.
- vga_b  out  3  blue overlay.
- pixel_active  out  1  overlay pixel is opaque.
- anim_busy  out  1  high while in BLINK or FLASH.

Behaviour:
- Reset: shown_lives=0, state=IDLE, frame counters=0, sprite_x/y=0, vga_r/g/b=0, pixel_active=0, anim_busy=0.
- Elaboration checks:
  - Fail if X_START+MAX_LIVES*(HEART_W+SPACING)-SPACING > 640.
  - Fail if Y_POS+HEART_H > 480.
- target = min(lives_in, MAX_LIVES).
- Life changes take effect only on frame_tick, so there is no mid-frame tearing.
- Pipeline, total latency 3 clocks from h_count/v_count to vga:
  - Clock 1: slot hit decoded from per-slot constant start columns (no divider). Registers sprite_x, sprite_y, slot index k and in_strip.
  - Clock 2: pixel_data valid. k and in_strip are delayed alongside it.
  - Clock 3: RGB and pixel_active registered.
- Outside every slot, sprite_x/sprite_y = 0.
- Slot k is visible when any of these holds:
  - k < shown_lives and state != BLINK;
  - k < blink_lo;
  - state = BLINK, blink_lo <= k < shown_lives, and blink phase = on.
- Opacity: pixel_data==6'b000000 is transparent, giving rgb=0 and pixel_active=0.
- Colour expansion replicates the MSB: r={pd[5:4],pd[5]}, and likewise for g and b.
- FLASH state: opaque pixels of slots flash_lo <= k < shown_lives output 3'b111 on r, g and b.
- State machine, evaluated on frame_tick only:
  - IDLE, target<shown_lives: go to BLINK. blink_lo=target, blink_cnt=0, phase=on.
  - IDLE, target>shown_lives: go to FLASH. flash_lo=shown_lives, shown_lives=target, flash_cnt=0.
  - IDLE, target==shown_lives: stay in IDLE.
  - BLINK, per tick: blink_cnt+1. Phase toggles each BLINK_HALF frames. When blink_cnt==BLINK_FRAMES-1: shown_lives=blink_lo and go to IDLE.
  - BLINK, target<blink_lo: blink_lo=target, blink_cnt=0, phase=on. The blink range widens, and hearts already blinking keep blinking.
  - BLINK, target>=shown_lives: abort the blink. If target>shown_lives, go to FLASH with flash_lo=shown_lives and shown_lives=target. Otherwise go to IDLE.
  - BLINK, blink_lo<target<shown_lives: blink_lo=target and the counter continues.
  - FLASH, per tick: flash_cnt+1. At FLASH_FRAMES-1, go to IDLE.
  - FLASH, target<shown_lives: go to BLINK as from IDLE.
  - FLASH, target>shown_lives: shown_lives=target and flash_cnt=0. flash_lo is unchanged.
- anim_busy = (state != IDLE), registered.
- Reset mid-animation: all state clears on the next clock. No hearts are shown until the next frame_tick loads target through the FLASH path from 0.
- lives_in > MAX_LIVES is clamped, with no error.

Test Plan:
- Reset, then lives_in=3 and one frame_tick: FLASH for 6 frames with slots 0-2 white, then normal colour. Slots 3-4 stay transparent. anim_busy is high for exactly 6 frames.
- Latency: h_count=160, v_count=456 with BRAM model returning 6'b110000 → sprite_x=0/sprite_y=0 at +1 clk. vga_r=3'b111, vga_g=0, pixel_active=1 at +3 clk.
- Transparent pixel: pixel_data=0 inside slot 1 → rgb=0, pixel_active=0. At h_count=176 (the gap) the addresses are 0 and there is no output.
- Loss: idle with lives=3, lives_in→2 → slot 2 is visible in frames 0-3, hidden in 4-7, and so on for 24 frames. Then shown_lives=2, IDLE, and slot 2 is permanently off.
- Double loss mid-blink: at blink frame 10, lives_in→0 → blink_lo=0 and the counter restarts. All 3 slots blink for 24 more frames, then none are shown.
- Gain mid-blink plus clamp: blinking 3→2, lives_in→7 → aborts to FLASH. Slots 3-4 flash white and shown_lives=5.
